// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//
// Shared definitions for the spiking-network datapath blocks.
//
// Contents:
//   CURRENT_W    width of a synaptic current / accumulator word
//   CURRENT_SAT  value an accumulator clips to on overflow
//   state_t      FSM state type for synapse_current_driver, plus its
//                two legal encodings ST_ACCUM / ST_FLUSH
//   sat_sum_t    result of a saturating add (sum + clip indication)
//   sat_add()    saturating unsigned add of two CURRENT_W words
// ---------------------------------------------------------------------------
package snn_pkg;

   localparam int CURRENT_W = 16;
   localparam logic [CURRENT_W-1:0] CURRENT_SAT = 16'hFFFF;

   // Two-state FSM kept as plain logic constants so the encoding stays
   // compatible with older tooling that dislikes enums on ports.
   typedef logic [0:0] state_t;
   localparam state_t ST_ACCUM = 1'b0;
   localparam state_t ST_FLUSH = 1'b1;

   typedef struct packed {
      logic [CURRENT_W-1:0] sum;
      logic                 clipped;
   } sat_sum_t;

   // Add in one extra bit of headroom; the carry out is exactly the
   // "would have wrapped" condition, so it doubles as the clip flag.
   function automatic sat_sum_t sat_add(input logic [CURRENT_W-1:0] a,
                                        input logic [CURRENT_W-1:0] b);
      logic [CURRENT_W:0] wide;
      sat_sum_t           res;
      wide        = {1'b0, a} + {1'b0, b};
      res.clipped = wide[CURRENT_W];
      res.sum     = res.clipped ? CURRENT_SAT : wide[CURRENT_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/synapse_weight_regfile.sv
// ---------------------------------------------------------------------------
// synapse_weight_regfile
//
// N_SRC x N_TGT array of unsigned synaptic weights. One synchronous write
// port addresses a single (source, target) cell; one combinational read
// port returns the full row for a source, all targets side by side.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears every weight to 0
//   we       write strobe
//   wr_src   write row (source address)
//   wr_tgt   write column (target index)
//   wr_data  weight value to store
//   rd_src   read row (source address)
//   rd_row   weights of row rd_src; target t in bits [W*t +: W]
//
// A write is visible on rd_row only after the clock edge that performs it,
// so a same-cycle reader sees the old weight.
// ---------------------------------------------------------------------------
module synapse_weight_regfile #(
   parameter int N_SRC   = 16,
   parameter int N_TGT   = 4,
   parameter int W_WIDTH = 8,
   parameter int SRC_AW  = 4,
   parameter int TGT_AW  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [SRC_AW-1:0]          wr_src,
   input  logic [TGT_AW-1:0]          wr_tgt,
   input  logic [W_WIDTH-1:0]         wr_data,
   input  logic [SRC_AW-1:0]          rd_src,
   output logic [N_TGT*W_WIDTH-1:0]   rd_row
);

   logic [W_WIDTH-1:0] mem [N_SRC][N_TGT];

   // NOTE: sequential state is assigned with <= so every register samples
   // its pre-edge inputs; blocking = here would create order-dependent
   // simulation and can disagree with the synthesized flops.
   // NOTE: this array is reset because the driver must see all-zero
   // weights after reset; that costs a reset net per cell, so it is a
   // flop array, not something to map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < N_SRC; s++) begin
            for (int t = 0; t < N_TGT; t++) begin
               mem[s][t] <= '0;
            end
         end
      end else if (we && (int'(wr_tgt) < N_TGT)) begin
         mem[wr_src][wr_tgt] <= wr_data;
      end
   end

   // NOTE: a default assignment heads every always_comb so no path leaves
   // an output unassigned, which is what would otherwise infer a latch.
   always_comb begin
      rd_row = '0;
      for (int t = 0; t < N_TGT; t++) begin
         rd_row[t*W_WIDTH +: W_WIDTH] = mem[rd_src][t];
      end
   end

endmodule

// File: rtl/synapse_current_driver.sv
// ---------------------------------------------------------------------------
// synapse_current_driver
//
// Collects presynaptic spike events over a timestep and delivers the summed,
// weighted current to N_TGT leaky-integrate-and-fire neurons once per
// timestep.
//
// Operation: in ACCUM every accepted event adds its weight row into the
// per-target accumulators (saturating at CURRENT_SAT). A timestep_tick moves
// to FLUSH; the FLUSH cycle presents every accumulator on current_out,
// strobes current_valid for the nonzero ones, clears the accumulators and
// returns to ACCUM. An event accepted together with the tick is included.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   ev_valid       spike event present
//   ev_src         source address of the event
//   ev_ready       event accepted when ev_valid && ev_ready at an edge
//   timestep_tick  one-cycle pulse ending the current timestep
//   cfg_we         weight write strobe (honoured in any state)
//   cfg_src        weight row select
//   cfg_tgt        weight column select
//   cfg_wdata      weight value
//   current_out    per-target current, target t in bits [16t+15:16t]
//   current_valid  per-target strobe, high only in FLUSH for nonzero current
//   overrun        sticky: a tick arrived while in FLUSH (it was dropped)
//   saturated      sticky: an accumulator clipped at CURRENT_SAT
// ---------------------------------------------------------------------------
module synapse_current_driver
   import snn_pkg::*;
#(
   parameter  int N_SRC   = 16,
   parameter  int N_TGT   = 4,
   parameter  int W_WIDTH = 8,
   parameter  int SRC_AW  = 4,
   localparam int TGT_AW  = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ev_valid,
   input  logic [SRC_AW-1:0]          ev_src,
   output logic                       ev_ready,
   input  logic                       timestep_tick,
   input  logic                       cfg_we,
   input  logic [SRC_AW-1:0]          cfg_src,
   input  logic [TGT_AW-1:0]          cfg_tgt,
   input  logic [W_WIDTH-1:0]         cfg_wdata,
   output logic [N_TGT*CURRENT_W-1:0] current_out,
   output logic [N_TGT-1:0]           current_valid,
   output logic                       overrun,
   output logic                       saturated
);

   state_t                 state_q;
   logic [CURRENT_W-1:0]   acc_q [N_TGT];
   logic                   overrun_q;
   logic                   saturated_q;

   logic [N_TGT*W_WIDTH-1:0] w_row;
   sat_sum_t               sums [N_TGT];
   logic [N_TGT-1:0]       clip;
   logic                   ev_accept;
   logic                   any_clip;

   // -----------------------------------------------------------------------
   // Weight storage. The read row is addressed by the incoming event so the
   // whole row is available combinationally in the accept cycle.
   // -----------------------------------------------------------------------
   synapse_weight_regfile #(
      .N_SRC   (N_SRC),
      .N_TGT   (N_TGT),
      .W_WIDTH (W_WIDTH),
      .SRC_AW  (SRC_AW),
      .TGT_AW  (TGT_AW)
   ) u_weights (
      .clk     (clk),
      .rst     (rst),
      .we      (cfg_we),
      .wr_src  (cfg_src),
      .wr_tgt  (cfg_tgt),
      .wr_data (cfg_wdata),
      .rd_src  (ev_src),
      .rd_row  (w_row)
   );

   // Ready is held low during reset (not just after it) so no event can be
   // handshaken while the block is being cleared.
   assign ev_ready  = (state_q == ST_ACCUM) && !rst;
   assign ev_accept = ev_valid && ev_ready;

   // -----------------------------------------------------------------------
   // Per-target saturating sums of accumulator + zero-extended weight.
   // -----------------------------------------------------------------------
   always_comb begin
      clip = '0;
      for (int t = 0; t < N_TGT; t++) begin
         sums[t] = sat_add(acc_q[t], CURRENT_W'(w_row[t*W_WIDTH +: W_WIDTH]));
         clip[t] = sums[t].clipped;
      end
   end

   assign any_clip = ev_accept && (|clip);

   // -----------------------------------------------------------------------
   // FSM, accumulators and sticky flags.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         overrun_q   <= 1'b0;
         saturated_q <= 1'b0;
         for (int t = 0; t < N_TGT; t++) begin
            acc_q[t] <= '0;
         end
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (ev_accept) begin
                  for (int t = 0; t < N_TGT; t++) begin
                     acc_q[t] <= sums[t].sum;
                  end
               end
               if (any_clip) begin
                  saturated_q <= 1'b1;
               end
               // The tick-cycle event is already folded in above, so the
               // flush that follows includes it.
               if (timestep_tick) begin
                  state_q <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               // Outputs present acc_q during this cycle; clearing here
               // means the next timestep starts from zero.
               for (int t = 0; t < N_TGT; t++) begin
                  acc_q[t] <= '0;
               end
               state_q <= ST_ACCUM;
               // A second tick cannot start another flush; it is dropped
               // and recorded.
               if (timestep_tick) begin
                  overrun_q <= 1'b1;
               end
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Outputs. Everything is forced to zero while rst is high, so a reset
   // landing on the FLUSH cycle suppresses that cycle's pulse immediately
   // rather than one edge later.
   // -----------------------------------------------------------------------
   always_comb begin
      current_out   = '0;
      current_valid = '0;
      if ((state_q == ST_FLUSH) && !rst) begin
         for (int t = 0; t < N_TGT; t++) begin
            current_out[t*CURRENT_W +: CURRENT_W] = acc_q[t];
            current_valid[t]                      = |acc_q[t];
         end
      end
   end

   assign overrun   = overrun_q   && !rst;
   assign saturated = saturated_q && !rst;

endmodule

// File: tb/tb_synapse_current_driver.sv
// ---------------------------------------------------------------------------
// tb_synapse_current_driver
//
// Directed scenarios followed by randomized traffic. The driver keeps a
// behavioural model (weight table, per-target running sums, "a flush is due"
// flag, sticky flags) and queues the expected flush for the cycle it must
// appear in; an independent monitor compares DUT outputs every cycle.
// ---------------------------------------------------------------------------
module tb_synapse_current_driver;

   localparam int N_SRC   = 16;
   localparam int N_TGT   = 4;
   localparam int W_WIDTH = 8;
   localparam int SRC_AW  = 4;

   logic                 clk;
   logic                 rst;
   logic                 ev_valid;
   logic [SRC_AW-1:0]    ev_src;
   logic                 ev_ready;
   logic                 timestep_tick;
   logic                 cfg_we;
   logic [SRC_AW-1:0]    cfg_src;
   logic [1:0]           cfg_tgt;
   logic [W_WIDTH-1:0]   cfg_wdata;
   logic [N_TGT*16-1:0]  current_out;
   logic [N_TGT-1:0]     current_valid;
   logic                 overrun;
   logic                 saturated;

   synapse_current_driver #(
      .N_SRC   (N_SRC),
      .N_TGT   (N_TGT),
      .W_WIDTH (W_WIDTH),
      .SRC_AW  (SRC_AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ev_valid      (ev_valid),
      .ev_src        (ev_src),
      .ev_ready      (ev_ready),
      .timestep_tick (timestep_tick),
      .cfg_we        (cfg_we),
      .cfg_src       (cfg_src),
      .cfg_tgt       (cfg_tgt),
      .cfg_wdata     (cfg_wdata),
      .current_out   (current_out),
      .current_valid (current_valid),
      .overrun       (overrun),
      .saturated     (saturated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [63:0] out;
      logic [3:0]  vld;
   } flush_t;

   flush_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc_no = 0;
   bit mon_en = 1'b0;

   // Expected values for the monitor, valid for the current cycle.
   logic exp_ready = 1'b0;
   logic exp_ovr   = 1'b0;
   logic exp_sat   = 1'b0;

   // Behavioural model state (value after the most recent edge).
   int unsigned m_w   [N_SRC][N_TGT];
   int unsigned m_acc [N_TGT];
   bit          m_flush = 1'b0;
   bit          m_ovr   = 1'b0;
   bit          m_sat   = 1'b0;

   initial begin
      foreach (m_w[s, t]) m_w[s][t] = 0;
      foreach (m_acc[t])  m_acc[t]  = 0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_no, act, exp);
      end
   endtask

   // One clock cycle of stimulus plus the model step for the edge ending it.
   task automatic cycle(input bit r, input bit v, input logic [3:0] src, input bit tk,
                        input bit we, input logic [3:0] wsrc, input logic [1:0] wtgt,
                        input logic [7:0] wd);
      flush_t      f;
      int unsigned s;
      bit          any;
      @(posedge clk);
      #1;
      cyc_no++;
      rst           = r;
      ev_valid      = v;
      ev_src        = src;
      timestep_tick = tk;
      cfg_we        = we;
      cfg_src       = wsrc;
      cfg_tgt       = wtgt;
      cfg_wdata     = wd;

      exp_ready = !m_flush && !r;
      exp_ovr   = m_ovr && !r;
      exp_sat   = m_sat && !r;

      // A due flush shows up this cycle unless reset cancels it.
      if (m_flush && !r) begin
         f.cyc = cyc_no;
         f.out = '0;
         f.vld = '0;
         any   = 1'b0;
         for (int t = 0; t < N_TGT; t++) begin
            f.out[t*16 +: 16] = m_acc[t][15:0];
            f.vld[t]          = (m_acc[t] != 0);
            any               = any | (m_acc[t] != 0);
         end
         if (any) exp_q.push_back(f);
      end

      // Model state after the coming edge.
      if (r) begin
         foreach (m_w[i, j]) m_w[i][j] = 0;
         foreach (m_acc[i])  m_acc[i]  = 0;
         m_flush = 1'b0;
         m_ovr   = 1'b0;
         m_sat   = 1'b0;
      end else begin
         if (m_flush) begin
            if (tk) m_ovr = 1'b1;
            foreach (m_acc[i]) m_acc[i] = 0;
            m_flush = 1'b0;
         end else begin
            if (v) begin
               for (int t = 0; t < N_TGT; t++) begin
                  s = m_acc[t] + m_w[src][t];
                  if (s > 65535) begin
                     s     = 65535;
                     m_sat = 1'b1;
                  end
                  m_acc[t] = s;
               end
            end
            if (tk) m_flush = 1'b1;
         end
         if (we) m_w[wsrc][wtgt] = wd;
      end
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic ev(input logic [3:0] src);
      cycle(0, 1, src, 0, 0, 0, 0, 0);
   endtask
   task automatic tick();
      cycle(0, 0, 0, 1, 0, 0, 0, 0);
   endtask
   task automatic wr(input logic [3:0] s, input logic [1:0] t, input logic [7:0] d);
      cycle(0, 0, 0, 0, 1, s, t, d);
   endtask

   // Monitor: independent of the driver, checks every cycle at negedge.
   initial begin
      flush_t f;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("ev_ready", 64'(ev_ready), 64'(exp_ready));
            check("overrun", 64'(overrun), 64'(exp_ovr));
            check("saturated", 64'(saturated), 64'(exp_sat));
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_no) begin
               f = exp_q.pop_front();
               check("flush_out", current_out, f.out);
               check("flush_valid", 64'(current_valid), 64'(f.vld));
            end else begin
               check("quiet_valid", 64'(current_valid), 64'd0);
               check("quiet_out", current_out, 64'd0);
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      ev_valid      = 1'b0;
      ev_src        = '0;
      timestep_tick = 1'b0;
      cfg_we        = 1'b0;
      cfg_src       = '0;
      cfg_tgt       = '0;
      cfg_wdata     = '0;
      @(posedge clk);
      mon_en = 1'b1;
      cycle(1, 1, 3, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("reset_ready", 64'(ev_ready), 64'd0);
      idle();
      #2;
      check("ready_after_reset", 64'(ev_ready), 64'd1);

      // Scenario 1: two weights on src 3, three events.
      wr(3, 0, 10);
      wr(3, 2, 5);
      repeat (3) ev(3);
      tick();
      idle();
      #2;
      check("s1_t0", 64'(current_out[15:0]), 64'd30);
      check("s1_t2", 64'(current_out[47:32]), 64'd15);
      check("s1_valid", 64'(current_valid), 64'b0101);
      idle();

      // Scenario 2: saturation.
      wr(1, 1, 255);
      repeat (300) ev(1);
      tick();
      idle();
      #2;
      check("s2_t1", 64'(current_out[31:16]), 64'hFFFF);
      check("s2_sat", 64'(saturated), 64'd1);
      idle();

      // Scenario 3: event in the tick cycle.
      wr(5, 1, 7);
      cycle(0, 1, 5, 1, 0, 0, 0, 0);
      idle();
      #2;
      check("s3_t1", 64'(current_out[31:16]), 64'd7);
      check("s3_ready", 64'(ev_ready), 64'd0);
      idle();

      // Scenario 4: back-to-back ticks.
      ev(3);
      tick();
      tick();
      idle();
      #2;
      check("s4_overrun", 64'(overrun), 64'd1);
      check("s4_no_second", 64'(current_valid), 64'd0);

      // Scenario 5: weight write racing an event on the same row.
      wr(2, 3, 4);
      cycle(0, 1, 2, 0, 1, 2, 3, 9);
      ev(2);
      tick();
      idle();
      #2;
      check("s5_t3", 64'(current_out[63:48]), 64'd13);

      // Scenario 6: reset on the flush cycle.
      wr(4, 0, 20);
      ev(4);
      tick();
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("s6_no_pulse", 64'(current_valid), 64'd0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      #2;
      check("s6_after", 64'(current_valid), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 399) == 0,
               $urandom_range(0, 9) < 6,
               4'($urandom_range(0, 15)),
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 3) == 0,
               4'($urandom_range(0, 15)),
               2'($urandom_range(0, 3)),
               8'($urandom_range(0, 255)));
      end
      idle();
      idle();
      @(negedge clk);
      #1;
      check("pending_flushes", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/synapse_current_driver.md
SYNAPSE_CURRENT_DRIVER -- requirements
Module: synapse_current_driver

Interface
REQ-001 Parameter N_SRC, default 16, number of presynaptic source addresses.
REQ-002 Parameter N_TGT, default 4, number of driven LIF neurons.
REQ-003 Parameter W_WIDTH, default 8, unsigned synaptic weight width.
REQ-004 Parameter SRC_AW, default 4, source address width, with N_SRC = 2**SRC_AW.
REQ-005 Port clk, input, 1, single clock, all logic rising-edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port ev_valid, input, 1, incoming spike event present.
REQ-008 Port ev_src, input, SRC_AW, source address of the event.
REQ-009 Port ev_ready, output, 1, event accepted when ev_valid and ev_ready are both high on a clock edge.
REQ-010 Port timestep_tick, input, 1, one-cycle pulse ending the current timestep.
REQ-011 Port cfg_we, input, 1, weight write strobe.
REQ-012 Port cfg_src, input, SRC_AW, weight row select.
REQ-013 Port cfg_tgt, input, 2, weight column select (log2 N_TGT).
REQ-014 Port cfg_wdata, input, W_WIDTH, weight value.
REQ-015 Port current_out, output, N_TGT*16, per-target current, target t in bits [16t+15:16t]; connects to each neuron's current_in.
REQ-016 Port current_valid, output, N_TGT, per-target strobe; connects to each neuron's spike_in_valid.
REQ-017 Port overrun, output, 1, sticky: timestep_tick arrived while in FLUSH.
REQ-018 Port saturated, output, 1, sticky: an accumulator clipped at 16'hFFFF.

Function
REQ-019 The FSM SHALL have exactly two states: ACCUM and FLUSH.
REQ-020 In ACCUM, ev_ready SHALL be 1; in FLUSH, ev_ready SHALL be 0.
REQ-021 An accepted event SHALL add weight[ev_src][t], zero-extended, to acc[t] for every target t in the same cycle.
REQ-022 Accumulator additions SHALL saturate at 16'hFFFF, and any clip SHALL set saturated.
REQ-023 timestep_tick in ACCUM SHALL move the FSM to FLUSH on the next edge.
REQ-024 An event accepted in the same cycle as that tick SHALL be included in the flush.
REQ-025 In FLUSH, for exactly one cycle: current_out[t] SHALL equal acc[t], and current_valid[t] SHALL be 1 only if acc[t] is nonzero.
REQ-026 On the FLUSH cycle, all accumulators SHALL clear and the FSM SHALL return to ACCUM.
REQ-027 In every cycle outside FLUSH, current_valid SHALL be 0 and current_out SHALL be 0.
REQ-028 Latency SHALL be exactly one cycle from the tick edge to the current_valid cycle.
REQ-029 timestep_tick received while in FLUSH SHALL be ignored and SHALL set overrun.
REQ-030 A weight write SHALL take effect on the next edge, with the old weight used for an event accepted in the same cycle.
REQ-031 Weight writes SHALL be accepted in any state.
REQ-032 Sticky flags SHALL clear only on rst.

Reset
REQ-033 While rst is high: state SHALL be ACCUM, all accumulators and weights SHALL be 0, and current_out, current_valid, overrun and saturated SHALL be 0.
REQ-034 While rst is high, ev_ready SHALL be 0; it rises on the first cycle after rst deasserts.
REQ-035 Reset asserted mid-FLUSH or mid-accumulation SHALL discard all pending current with no valid pulse.

Structure
REQ-036 A shared package snn_pkg SHALL hold the FSM state type, CURRENT_W = 16, and the saturation constant.
REQ-037 Weight storage SHALL be one sub-module, synapse_weight_regfile.
REQ-038 synapse_weight_regfile SHALL be an N_SRC x N_TGT register array with one write port and a full-row combinational read.

Verification
REQ-039 Scenario 1: set weight[3][0]=10 and weight[3][2]=5, send 3 events from src 3, pulse tick -> one cycle later current_out t0=30 and t2=15, current_valid=4'b0101.
REQ-040 Scenario 2: weight[1][1]=255, send 300 events from src 1, tick -> t1 output 16'hFFFF, saturated=1.
REQ-041 Scenario 3: event and tick in the same cycle with weight 7 -> the flush includes 7, and ev_ready=0 during the FLUSH cycle.
REQ-042 Scenario 4: tick on two consecutive cycles -> only one flush occurs and overrun=1.
REQ-043 Scenario 5: write weight[2][3] from 4 to 9 in the same cycle as a src 2 event, then send a second src 2 event, tick -> t3 output 13.
REQ-044 Scenario 6: accumulate 20 on t0, assert rst during the FLUSH cycle -> no valid pulse, and after reset a tick produces current_valid=0.
